// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings for the SRAM port arbiter (ARB_PERF_EN adds perf counters)
package mem_port_arbiter_pkg;
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_WAIT   = 2'd2,
      ARB_RESP   = 2'd3
   } arbState_t;
   localparam logic       OWNER_I = 1'b0;
   localparam logic       OWNER_D = 1'b1;
   localparam logic [3:0] WE_NONE = 4'b0000;
   localparam int         LAT_W   = 3;
endpackage

// File: rtl/mem_port_arbiter_perf_cnt.sv
// arb_perf_cnt: 32-bit wrapping event counter with enable, cleared by synchronous active-low reset
module arb_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [31:0] count
);
   always_ff @(posedge clk)
      if (!rst) count <= '0;
      else if (en) count <= count + 32'd1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port SRAM between fetch (I) and data (D) ports, D over I; ARB_PERF_EN adds perf counters
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic [31:0]       i_rdata,
   output logic              i_ready,
   input  logic              d_req,
   input  logic [3:0]        d_we,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_ready,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
`ifdef ARB_PERF_EN
  ,output logic [31:0]       perf_d_grants,
   output logic [31:0]       perf_i_grants,
   output logic [31:0]       perf_conflicts
`endif
);
   arbState_t        state, nextState;
   logic             owner;
   logic             isWrite;
   logic [LAT_W-1:0] latCnt;
   logic             grantD, grantI, lastBeat;
   logic             unusedAddrBits;

   assign grantD   = (state == ARB_IDLE) && d_req;
   assign grantI   = (state == ARB_IDLE) && !d_req && i_req;
   assign lastBeat = (state == ARB_WAIT) && (latCnt == LAT_W'(1));
   assign i_ready  = (state == ARB_RESP) && (owner == OWNER_I);
   assign d_ready  = (state == ARB_RESP) && (owner == OWNER_D);
   assign unusedAddrBits = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

   always_ff @(posedge clk)
      if (!rst) state <= ARB_IDLE;
      else state <= nextState;

   always_comb begin
      nextState = state;
      case (state)
         ARB_IDLE:   nextState = (d_req || i_req) ? ARB_ACCESS : ARB_IDLE;
         ARB_ACCESS: nextState = isWrite ? ARB_RESP : ARB_WAIT;
         ARB_WAIT:   nextState = lastBeat ? ARB_RESP : ARB_WAIT;
         default:    nextState = ARB_IDLE;
      endcase
   end

   // SRAM controls are loaded on the grant edge so they are registered and valid in ACCESS.
   always_ff @(posedge clk)
      if (!rst) begin
         owner     <= OWNER_I;
         isWrite   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= WE_NONE;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= grantD || grantI;
         mem_we <= grantD ? d_we : WE_NONE;
         if (grantD || grantI) begin
            owner    <= grantD ? OWNER_D : OWNER_I;
            isWrite  <= grantD && (d_we != WE_NONE);
            mem_addr <= grantD ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
         end
         if (grantD) mem_wdata <= d_wdata;
      end

   always_ff @(posedge clk)
      if (!rst) latCnt <= '0;
      else if (state == ARB_ACCESS && !isWrite) latCnt <= LAT_W'(READ_LAT);
      else if (state == ARB_WAIT) latCnt <= latCnt - LAT_W'(1);

   always_ff @(posedge clk)
      if (!rst) begin
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         if (lastBeat && owner == OWNER_I) i_rdata <= mem_rdata;
         if (lastBeat && owner == OWNER_D) d_rdata <= mem_rdata;
      end

`ifdef ARB_PERF_EN
   arb_perf_cnt dGrantCnt (.clk(clk), .rst(rst), .en(grantD), .count(perf_d_grants));
   arb_perf_cnt iGrantCnt (.clk(clk), .rst(rst), .en(grantI), .count(perf_i_grants));
   arb_perf_cnt conflictCnt (.clk(clk), .rst(rst), .en((state == ARB_IDLE) && i_req && d_req), .count(perf_conflicts));
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench, instance 0 at READ_LAT=1 and instance 1 at READ_LAT=3; ARB_PERF_EN checks counters
module tb_mem_port_arbiter;
   typedef struct {
      int          k;
      int          port;
      int          due;
      logic [31:0] expI;
      logic [31:0] expD;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  iReq, dReq, iReady, dReady, memEn;
   logic [31:0] iAddr[2], dAddr[2], dWdata[2], iRdata[2], dRdata[2], memWdata[2], memRdata[2];
   logic [3:0]  dWe[2], memWe[2];
   logic [15:0] memAddr[2];
`ifdef ARB_PERF_EN
   logic [31:0] perfD[2], perfI[2], perfC[2];
`endif
   logic [31:0] sram[2][64];
   logic [31:0] model[2][64];
   logic [31:0] pipeD[2][8];
   logic [7:0]  pipeV[2];
   logic [31:0] lastI[2], lastD[2];
   int          expDG[2], expIG[2], expCf[2];
   int          total = 0, bad = 0, cyc = 0;
   exp_t        expQ[$];
   exp_t        e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat(int k);
      return k ? 3 : 1;
   endfunction

   function automatic logic [31:0] initVal(int i);
      return (i == 4) ? 32'hDEADBEEF : 32'h5A000000 + i * 32'h00010203;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : inst
      localparam int LAT = g ? 3 : 1;
      mem_port_arbiter #(.ADDR_W(16), .READ_LAT(LAT)) dut (
         .clk(clk), .rst(rst),
         .i_req(iReq[g]), .i_addr(iAddr[g]), .i_rdata(iRdata[g]), .i_ready(iReady[g]),
         .d_req(dReq[g]), .d_we(dWe[g]), .d_addr(dAddr[g]), .d_wdata(dWdata[g]),
         .d_rdata(dRdata[g]), .d_ready(dReady[g]),
         .mem_en(memEn[g]), .mem_we(memWe[g]), .mem_addr(memAddr[g]),
         .mem_wdata(memWdata[g]), .mem_rdata(memRdata[g])
`ifdef ARB_PERF_EN
        ,.perf_d_grants(perfD[g]), .perf_i_grants(perfI[g]), .perf_conflicts(perfC[g])
`endif
      );
      assign memRdata[g] = pipeV[g][LAT-1] ? pipeD[g][LAT-1] : 32'hBADBAD00;
   end

   // SRAM model: data appears READ_LAT cycles after the enable cycle, junk otherwise
   always @(posedge clk)
      for (int k = 0; k < 2; k++)
         if (cyc == 0) begin
            pipeV[k] <= '0;
            for (int i = 0; i < 64; i++) sram[k][i] <= initVal(i);
         end else begin
            for (int j = 7; j > 0; j--) pipeD[k][j] <= pipeD[k][j-1];
            pipeV[k] <= {pipeV[k][6:0], memEn[k] && memWe[k] == 4'b0000};
            pipeD[k][0] <= sram[k][memAddr[k][5:0]];
            if (memEn[k])
               for (int b = 0; b < 4; b++)
                  if (memWe[k][b]) sram[k][memAddr[k][5:0]][8*b +: 8] <= memWdata[k][8*b +: 8];
         end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   always @(negedge clk)
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < 2; p++)
            if (p ? dReady[k] : iReady[k]) begin
               if (expQ.size() == 0) check("spurious ready", 32'(k * 2 + p), 32'hFFFFFFFF);
               else begin
                  e = expQ.pop_front();
                  check("ready owner", 32'(k * 2 + p), 32'(e.k * 2 + e.port));
                  check("ready cycle", cyc, e.due);
                  check("i_rdata", iRdata[k], e.expI);
                  check("d_rdata", dRdata[k], e.expD);
               end
            end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(int k, int port, int due, logic [3:0] we, logic [31:0] addr, logic [31:0] wdata);
      if (port == 0) lastI[k] = model[k][addr[7:2]];
      else if (we == 4'b0000) lastD[k] = model[k][addr[7:2]];
      else
         for (int b = 0; b < 4; b++)
            if (we[b]) model[k][addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
      expQ.push_back('{k, port, due, lastI[k], lastD[k]});
   endtask

   task automatic waitDone(int k, int port);
      int t = 0;
      while (!(port ? dReady[k] : iReady[k]) && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("ready seen", 32'(port ? dReady[k] : iReady[k]), 32'd1);
      tick();
      if (port) dReq[k] = 1'b0;
      else iReq[k] = 1'b0;
   endtask

   // Issues one transaction on an idle arbiter and checks the SRAM-side cycle.
   task automatic xfer(int k, int port, logic [3:0] we, logic [31:0] addr, logic [31:0] wdata, bit dropEarly);
      int n = cyc;
      pushExp(k, port, n + 2 + ((port && we != 4'b0000) ? 0 : lat(k)), we, addr, wdata);
      if (port) begin
         dReq[k] = 1'b1; dWe[k] = we; dAddr[k] = addr; dWdata[k] = wdata;
         expDG[k]++;
      end else begin
         iReq[k] = 1'b1; iAddr[k] = addr;
         expIG[k]++;
      end
      @(negedge clk);
      check("mem_en before grant", 32'(memEn[k]), 32'd0);
      @(negedge clk);
      check("mem_en", 32'(memEn[k]), 32'd1);
      check("mem_addr", 32'(memAddr[k]), 32'(addr[17:2]));
      check("mem_we", 32'(memWe[k]), 32'(port ? we : 4'b0000));
      if (port && we != 4'b0000) check("mem_wdata", memWdata[k], wdata);
      if (dropEarly) begin
         tick();
         if (port) dReq[k] = 1'b0;
         else iReq[k] = 1'b0;
      end
      waitDone(k, port);
   endtask

   task automatic clearExp();
      for (int k = 0; k < 2; k++) begin
         lastI[k] = '0; lastD[k] = '0;
         expDG[k] = 0; expIG[k] = 0; expCf[k] = 0;
      end
   endtask

   initial begin
      int n, dueD;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 64; i++) model[k][i] = initVal(i);
         iAddr[k] = 32'h10; dAddr[k] = 32'h20; dWdata[k] = 32'hFFFFFFFF; dWe[k] = 4'hF;
      end
      clearExp();
      iReq = 2'b11;
      dReq = 2'b11;
      repeat (2) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            check("rst mem_en", 32'(memEn[k]), 32'd0);
            check("rst mem_we", 32'(memWe[k]), 32'd0);
            check("rst mem_addr", 32'(memAddr[k]), 32'd0);
            check("rst mem_wdata", memWdata[k], 32'd0);
            check("rst ready", 32'({iReady[k], dReady[k]}), 32'd0);
            check("rst i_rdata", iRdata[k], 32'd0);
            check("rst d_rdata", dRdata[k], 32'd0);
         end
      end
      tick();
      rst = 1'b1; iReq = 2'b00; dReq = 2'b00;
      tick();
      xfer(0, 0, 4'b0000, 32'h0000_0010, 32'h0, 1'b0);
      xfer(0, 1, 4'b0011, 32'h0000_0020, 32'h1234_5678, 1'b0);
      xfer(0, 1, 4'b0000, 32'h0000_0020, 32'h0, 1'b0);
      xfer(0, 1, 4'b1100, 32'hFFFF_0004, 32'hCAFE_F00D, 1'b0);
      xfer(0, 1, 4'b1111, 32'h0000_00FC, 32'h0BAD_CAFE, 1'b0);
      xfer(0, 0, 4'b0000, 32'h0000_00FC, 32'h0, 1'b0);
      // Both ports request in the same IDLE cycle.
      n = cyc;
      dueD = n + 2 + lat(0);
      pushExp(0, 1, dueD, 4'b0000, 32'h0000_0004, 32'h0);
      pushExp(0, 0, dueD + 3 + lat(0), 4'b0000, 32'h0000_0040, 32'h0);
      dReq[0] = 1'b1; dWe[0] = 4'b0000; dAddr[0] = 32'h4;
      iReq[0] = 1'b1; iAddr[0] = 32'h40;
      expDG[0]++; expIG[0]++; expCf[0]++;
      waitDone(0, 1);
      waitDone(0, 0);
`ifdef ARB_PERF_EN
      check("perf_conflicts", perfC[0], 32'(expCf[0]));
`endif
      xfer(1, 1, 4'b0000, 32'h0000_0010, 32'h0, 1'b1);
      xfer(1, 0, 4'b0000, 32'h0000_0024, 32'h0, 1'b0);
      xfer(1, 1, 4'b1111, 32'h0000_0030, 32'h7777_8888, 1'b0);
      xfer(1, 1, 4'b0000, 32'h0000_0030, 32'h0, 1'b0);
      // Reset lands while instance 1 waits on a 3-cycle read.
      iReq[1] = 1'b1; iAddr[1] = 32'h8;
      tick();
      tick();
      rst = 1'b0; iReq[1] = 1'b0;
      tick();
      rst = 1'b1;
      clearExp();
      repeat (6) begin
         @(negedge clk);
         check("post-rst i_ready", 32'(iReady[1]), 32'd0);
         check("post-rst mem_en", 32'(memEn[1]), 32'd0);
      end
      tick();
      xfer(1, 0, 4'b0000, 32'h0000_0008, 32'h0, 1'b0);
      xfer(0, 0, 4'b0000, 32'h0000_0020, 32'h0, 1'b0);
      repeat (3) tick();
`ifdef ARB_PERF_EN
      for (int k = 0; k < 2; k++) begin
         check("perf_d_grants", perfD[k], 32'(expDG[k]));
         check("perf_i_grants", perfI[k], 32'(expIG[k]));
         check("perf_conflicts end", perfC[k], 32'(expCf[k]));
      end
`endif
      check("scoreboard drained", 32'(expQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish by time %0t", $time);
      $fatal(1);
   end
endmodule
